lane_ctrl_pause_seq: RTL and testbench

//  Initiator side of the lane-controller clock-pause interface. On a 4-phase request it drives
//  HS_IO_CLK_PAUSE high, waits for the pause to take effect, issues a one-cycle delay/phase load

---
 rtl/lane_ctrl_pause_pkg.sv | 27 ++
 rtl/lane_ctrl_pause_seq_if.sv | 33 +++
 rtl/lane_ctrl_pause_cnt.sv | 35 +++
 rtl/lane_ctrl_pause_seq.sv | 140 ++++++++++++++
 tb/tb_lane_ctrl_pause_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lane_ctrl_pause_pkg.sv
// Shared types and defaults for the lane-controller clock-pause initiator.
// State encoding and default cycle counts live here so the FSM and bench agree.
package lane_ctrl_pause_pkg;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_SETUP_ENC   = 3'd1;
    localparam logic [2:0] ST_LOAD_ENC    = 3'd2;
    localparam logic [2:0] ST_HOLD_ENC    = 3'd3;
    localparam logic [2:0] ST_RELEASE_ENC = 3'd4;
    localparam logic [2:0] ST_DONE_ENC    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_SETUP   = ST_SETUP_ENC,
        ST_LOAD    = ST_LOAD_ENC,
        ST_HOLD    = ST_HOLD_ENC,
        ST_RELEASE = ST_RELEASE_ENC,
        ST_DONE    = ST_DONE_ENC
    } state_e;

    localparam int DEF_SETUP_CYCLES   = 4;
    localparam int DEF_HOLD_CYCLES    = 4;
    localparam int DEF_SETTLE_CYCLES  = 8;
    localparam int DEF_CNT_W          = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/lane_ctrl_pause_seq_if.sv
// Handshake and pause signals between the pause initiator and its environment.
// master = the pause sequencer, slave = requester / lane controller side.
interface lane_ctrl_pause_seq_if;

    logic UPDATE_REQ;
    logic UPDATE_ACK;
    logic HS_IO_CLK_PAUSE;
    logic DELAY_LOAD;
    logic BUSY;
    logic HS_IO_CLK_PAUSE_SYNC;
    logic SYNC_ERR;

    modport master (
        input  UPDATE_REQ,
        input  HS_IO_CLK_PAUSE_SYNC,
        output UPDATE_ACK,
        output HS_IO_CLK_PAUSE,
        output DELAY_LOAD,
        output BUSY,
        output SYNC_ERR
    );

    modport slave (
        output UPDATE_REQ,
        output HS_IO_CLK_PAUSE_SYNC,
        input  UPDATE_ACK,
        input  HS_IO_CLK_PAUSE,
        input  DELAY_LOAD,
        input  BUSY,
        input  SYNC_ERR
    );

endinterface

// File: rtl/lane_ctrl_pause_cnt.sv
// Load/decrement down-counter with zero flag; saturates at zero instead of wrapping.
module lane_ctrl_pause_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lane_ctrl_pause_seq.sv
// Clock-pause initiator: REQ -> pause, LOAD strobe, hold, release, settle -> ACK.
// Define LANE_PAUSE_SYNC_CHECK_EN to also wait on the synchronised pause feedback.
module lane_ctrl_pause_seq
    import lane_ctrl_pause_pkg::*;
#(
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RESET,
    lane_ctrl_pause_seq_if.master pif
);

    state_e           state_q, state_d;
    logic             pause_q, pause_d;
    logic             load_q, load_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             ph_load;
    logic [CNT_W-1:0] ph_val;
    logic             ph_zero;
    logic             fb_hi, fb_lo, timeout;

    lane_ctrl_pause_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (1'b1),
        .zero     (ph_zero)
    );

`ifdef LANE_PAUSE_SYNC_CHECK_EN
    logic wt_load, wt_zero;

    // The timeout window restarts on entry to each feedback wait.
    assign wt_load = ((state_q == ST_IDLE) && (state_d == ST_SETUP)) ||
                     ((state_q == ST_HOLD) && (state_d == ST_RELEASE));

    lane_ctrl_pause_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (wt_load),
        .load_val (CNT_W'(TIMEOUT_CYCLES - 1)),
        .dec      (1'b1),
        .zero     (wt_zero)
    );

    assign fb_hi   = pif.HS_IO_CLK_PAUSE_SYNC;
    assign fb_lo   = ~pif.HS_IO_CLK_PAUSE_SYNC;
    assign timeout = wt_zero;
`else
    logic sync_unused;
    assign sync_unused = pif.HS_IO_CLK_PAUSE_SYNC;
    assign fb_hi       = 1'b1;
    assign fb_lo       = 1'b1;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ph_load = 1'b0;
        ph_val  = '0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pif.UPDATE_REQ && !ack_q) begin
                    state_d = ST_SETUP;
                    ph_load = 1'b1;
                    ph_val  = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            ST_SETUP: begin
                if (ph_zero && (fb_hi || timeout)) begin
                    state_d = ST_LOAD;
                    err_d   = err_q | ~fb_hi;
                end
            end
            ST_LOAD: begin
                state_d = ST_HOLD;
                ph_load = 1'b1;
                ph_val  = CNT_W'(HOLD_CYCLES - 1);
            end
            ST_HOLD: begin
                if (ph_zero) begin
                    state_d = ST_RELEASE;
                    ph_load = 1'b1;
                    ph_val  = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_RELEASE: begin
                if (ph_zero && (fb_lo || timeout)) begin
                    state_d = ST_DONE;
                    err_d   = err_q | ~fb_lo;
                end
            end
            ST_DONE: begin
                if (!pif.UPDATE_REQ) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register with it.
        pause_d = (state_d == ST_SETUP) || (state_d == ST_LOAD) || (state_d == ST_HOLD);
        load_d  = (state_d == ST_LOAD);
        ack_d   = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            pause_q <= 1'b0;
            load_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pause_q <= pause_d;
            load_q  <= load_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign pif.UPDATE_ACK      = ack_q;
    assign pif.HS_IO_CLK_PAUSE = pause_q;
    assign pif.DELAY_LOAD      = load_q;
    assign pif.BUSY            = busy_q;
    assign pif.SYNC_ERR        = err_q;

endmodule

// File: tb/tb_lane_ctrl_pause_seq.sv
// Directed bench for lane_ctrl_pause_seq with default parameters.
// Feedback-check scenarios are built only when LANE_PAUSE_SYNC_CHECK_EN is defined.
module tb_lane_ctrl_pause_seq;
    import lane_ctrl_pause_pkg::*;

    logic CLK;
    logic RESET;
    int   n_pass;
    int   n_total;
    int   load_cnt;
    int   fb_mode;
    logic s1, s2;

    lane_ctrl_pause_seq_if pif ();

    lane_ctrl_pause_seq dut (
        .CLK   (CLK),
        .RESET (RESET),
        .pif   (pif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Lane-controller model: 2-flop synchroniser of pause, or feedback stuck at 0.
    always @(posedge CLK) begin
        s1 <= pif.HS_IO_CLK_PAUSE;
        s2 <= s1;
    end
    assign pif.HS_IO_CLK_PAUSE_SYNC = (fb_mode == 1) ? s2 : 1'b0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (pif.DELAY_LOAD === 1'b1) load_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // REQ already high in IDLE: pause at edge 1, LOAD at 5, pause low at 10, ACK at 18.
    task automatic run_seq(input string t);
        step(1);
        chk({t, "_pause_rise"}, pif.HS_IO_CLK_PAUSE, 1);
        chk({t, "_busy_rise"},  pif.BUSY, 1);
        chk({t, "_no_load_e1"}, pif.DELAY_LOAD, 0);
        step(3);
        chk({t, "_pause_e4"},   pif.HS_IO_CLK_PAUSE, 1);
        chk({t, "_no_load_e4"}, pif.DELAY_LOAD, 0);
        step(1);
        chk({t, "_load_e5"},    pif.DELAY_LOAD, 1);
        chk({t, "_pause_e5"},   pif.HS_IO_CLK_PAUSE, 1);
        step(1);
        chk({t, "_load_off_e6"}, pif.DELAY_LOAD, 0);
        chk({t, "_pause_e6"},   pif.HS_IO_CLK_PAUSE, 1);
        step(3);
        chk({t, "_pause_e9"},   pif.HS_IO_CLK_PAUSE, 1);
        step(1);
        chk({t, "_pause_fall_e10"}, pif.HS_IO_CLK_PAUSE, 0);
        chk({t, "_busy_e10"},   pif.BUSY, 1);
        step(7);
        chk({t, "_no_ack_e17"}, pif.UPDATE_ACK, 0);
        step(1);
        chk({t, "_ack_e18"},    pif.UPDATE_ACK, 1);
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        load_cnt       = 0;
        fb_mode        = 1;
        RESET          = 1'b1;
        pif.UPDATE_REQ = 1'b0;
        step(2);
        chk("rst_ack",   pif.UPDATE_ACK, 0);
        chk("rst_pause", pif.HS_IO_CLK_PAUSE, 0);
        chk("rst_load",  pif.DELAY_LOAD, 0);
        chk("rst_busy",  pif.BUSY, 0);
        chk("rst_err",   pif.SYNC_ERR, 0);
        RESET = 1'b0;
        step(1);
        chk("idle_busy", pif.BUSY, 0);

        // REQ held high through the whole handshake
        pif.UPDATE_REQ = 1'b1;
        load_cnt = 0;
        run_seq("t1");
        step(3);
        chk("t1_ack_held",   pif.UPDATE_ACK, 1);
        chk("t1_busy_done",  pif.BUSY, 1);
        chk("t1_pause_done", pif.HS_IO_CLK_PAUSE, 0);
        pif.UPDATE_REQ = 1'b0;
        step(1);
        chk("t1_ack_fall",  pif.UPDATE_ACK, 0);
        chk("t1_busy_fall", pif.BUSY, 0);
        chk("t1_load_cnt",  load_cnt, 1);

        // REQ pulsed for one cycle
        pif.UPDATE_REQ = 1'b1;
        load_cnt = 0;
        step(1);
        pif.UPDATE_REQ = 1'b0;
        chk("t2_pause_rise", pif.HS_IO_CLK_PAUSE, 1);
        step(16);
        chk("t2_no_ack_e17", pif.UPDATE_ACK, 0);
        chk("t2_busy_e17",   pif.BUSY, 1);
        step(1);
        chk("t2_ack_e18",    pif.UPDATE_ACK, 1);
        step(1);
        chk("t2_ack_1cyc",   pif.UPDATE_ACK, 0);
        chk("t2_idle",       pif.BUSY, 0);
        step(3);
        chk("t2_stay_idle",  pif.BUSY, 0);
        chk("t2_load_cnt",   load_cnt, 1);

        // REQ kept high after ACK: no second sequence until REQ drops
        pif.UPDATE_REQ = 1'b1;
        load_cnt = 0;
        run_seq("t4");
        step(10);
        chk("t4_ack_held",   pif.UPDATE_ACK, 1);
        chk("t4_no_repause", pif.HS_IO_CLK_PAUSE, 0);
        chk("t4_load_cnt",   load_cnt, 1);
        pif.UPDATE_REQ = 1'b0;
        step(1);
        chk("t4_ack_fall",   pif.UPDATE_ACK, 0);
        chk("t4_idle",       pif.BUSY, 0);
        pif.UPDATE_REQ = 1'b1;
        step(1);
        chk("t4_restart_pause", pif.HS_IO_CLK_PAUSE, 1);
        chk("t4_restart_busy",  pif.BUSY, 1);
        RESET = 1'b1;
        pif.UPDATE_REQ = 1'b0;
        step(1);
        RESET = 1'b0;
        step(1);
        chk("t4_clean_idle", pif.BUSY, 0);

        // Reset in HOLD, then a fresh request
        pif.UPDATE_REQ = 1'b1;
        step(7);
        chk("t3_in_hold_pause", pif.HS_IO_CLK_PAUSE, 1);
        load_cnt = 0;
        RESET = 1'b1;
        step(1);
        chk("t3_rst_pause", pif.HS_IO_CLK_PAUSE, 0);
        chk("t3_rst_busy",  pif.BUSY, 0);
        chk("t3_rst_load",  pif.DELAY_LOAD, 0);
        chk("t3_rst_ack",   pif.UPDATE_ACK, 0);
        RESET = 1'b0;
        pif.UPDATE_REQ = 1'b0;
        step(1);
        chk("t3_idle", pif.BUSY, 0);
        pif.UPDATE_REQ = 1'b1;
        load_cnt = 0;
        run_seq("t3");
        pif.UPDATE_REQ = 1'b0;
        step(1);
        chk("t3_ack_fall", pif.UPDATE_ACK, 0);
        chk("t3_load_cnt", load_cnt, 1);

`ifdef LANE_PAUSE_SYNC_CHECK_EN
        // Feedback follows pause through a 2-flop synchroniser
        fb_mode = 1;
        pif.UPDATE_REQ = 1'b1;
        run_seq("t5");
        chk("t5_no_err", pif.SYNC_ERR, 0);
        pif.UPDATE_REQ = 1'b0;
        step(1);

        // Feedback stuck low: LOAD only after the 64-cycle timeout
        fb_mode = 0;
        pif.UPDATE_REQ = 1'b1;
        step(64);
        chk("t6_no_load_e64", pif.DELAY_LOAD, 0);
        chk("t6_no_err_e64",  pif.SYNC_ERR, 0);
        step(1);
        chk("t6_load_e65",    pif.DELAY_LOAD, 1);
        chk("t6_err_e65",     pif.SYNC_ERR, 1);
        step(12);
        chk("t6_no_ack_e77",  pif.UPDATE_ACK, 0);
        step(1);
        chk("t6_ack_e78",     pif.UPDATE_ACK, 1);
        pif.UPDATE_REQ = 1'b0;
        step(1);
        chk("t6_ack_fall",    pif.UPDATE_ACK, 0);
        chk("t6_err_sticky",  pif.SYNC_ERR, 1);
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        chk("t6_err_cleared", pif.SYNC_ERR, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
